// File: rtl/id_stage_pkg.sv
// Shared ALU op codes and RV32I decode constants for the instruction decode stage.
package id_stage_pkg;

   typedef enum logic [4:0] {
      AluAdd  = 5'd0,
      AluSub  = 5'd1,
      AluSll  = 5'd2,
      AluSlt  = 5'd3,
      AluSltu = 5'd4,
      AluXor  = 5'd5,
      AluSrl  = 5'd6,
      AluSra  = 5'd7,
      AluOr   = 5'd8,
      AluAnd  = 5'd9
   } alu_op_e;

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] F7Base   = 7'b0000000;
   localparam logic [6:0] F7Alt    = 7'b0100000;
   localparam logic [2:0] F3AddSub = 3'b000;
   localparam logic [2:0] F3Sll    = 3'b001;
   localparam logic [2:0] F3Sr     = 3'b101;

   // alt selects SUB/SRA over ADD/SRL; it is ignored for the other funct3 values.
   function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
      alu_op_e res;
      case (f3)
         3'b000:  res = alt ? AluSub : AluAdd;
         3'b001:  res = AluSll;
         3'b010:  res = AluSlt;
         3'b011:  res = AluSltu;
         3'b100:  res = AluXor;
         3'b101:  res = alt ? AluSra : AluSrl;
         3'b110:  res = AluOr;
         default: res = AluAnd;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// 31x32 integer register file (x1..x31) with one write port and two bypassing read ports.
module id_regfile (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o
);

   logic [31:0] regs_q [31:1];
   logic [31:0] regs_d [31:1];

   always_comb begin
      regs_d = regs_q;
      if (we_i && (waddr_i != 5'd0)) regs_d[waddr_i] = wdata_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 1; i < 32; i++) regs_q[i] <= 32'd0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // x0 reads as zero; a same-cycle write to the read address is forwarded.
   always_comb begin
      if (raddr1_i == 5'd0)                      rdata1_o = 32'd0;
      else if (we_i && (waddr_i == raddr1_i))    rdata1_o = wdata_i;
      else                                       rdata1_o = regs_q[raddr1_i];
      if (raddr2_i == 5'd0)                      rdata2_o = 32'd0;
      else if (we_i && (waddr_i == raddr2_i))    rdata2_o = wdata_i;
      else                                       rdata2_o = regs_q[raddr2_i];
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: decodes OP/OP-IMM, reads operands, tracks busy registers and issues to the ALU.
module id_stage
   import id_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] rs1,
   output logic [31:0] rs2,
   output logic [4:0]  op,
   output logic [4:0]  rd,
   output logic        illegal,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        flush
);

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  src1, src2, dst;
   logic [31:0] rf_rdata1, rf_rdata2;

   logic        dec_legal, use_rs1, use_rs2, is_shift_imm;
   alu_op_e     dec_op;
   logic        byp1, byp2, hazard, accept;

   logic        out_valid_q, out_valid_d;
   logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic [4:0]  op_q, op_d, rd_q, rd_d;
   logic        illegal_q, illegal_d;
   logic [31:0] busy_q, busy_d;

   assign opcode = in_instr[6:0];
   assign dst    = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign src1   = in_instr[19:15];
   assign src2   = in_instr[24:20];
   assign funct7 = in_instr[31:25];

   id_regfile u_regfile (
      .clk_i    (clk),
      .reset_i  (reset),
      .we_i     (wb_en),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data),
      .raddr1_i (src1),
      .raddr2_i (src2),
      .rdata1_o (rf_rdata1),
      .rdata2_o (rf_rdata2)
   );

   always_comb begin
      dec_legal    = 1'b0;
      dec_op       = AluAdd;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
      is_shift_imm = 1'b0;
      if (opcode == OpcOp) begin
         use_rs1   = 1'b1;
         use_rs2   = 1'b1;
         dec_legal = (funct7 == F7Base) ||
                     ((funct7 == F7Alt) && ((funct3 == F3AddSub) || (funct3 == F3Sr)));
         dec_op    = f3_to_op(funct3, funct7 == F7Alt);
      end else if (opcode == OpcOpImm) begin
         use_rs1 = 1'b1;
         if ((funct3 == F3Sll) || (funct3 == F3Sr)) begin
            is_shift_imm = 1'b1;
            dec_legal    = (funct7 == F7Base) || ((funct7 == F7Alt) && (funct3 == F3Sr));
            dec_op       = f3_to_op(funct3, funct7 == F7Alt);
         end else begin
            // Upper bits are immediate here, so no SUB form exists.
            dec_legal = 1'b1;
            dec_op    = f3_to_op(funct3, 1'b0);
         end
      end
   end

   assign byp1   = wb_en && (wb_rd == src1) && (src1 != 5'd0);
   assign byp2   = wb_en && (wb_rd == src2) && (src2 != 5'd0);
   assign hazard = in_valid && ((use_rs1 && busy_q[src1] && !byp1) ||
                                (use_rs2 && busy_q[src2] && !byp2));

   assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush && !reset;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      op_d        = op_q;
      rd_d        = rd_q;
      illegal_d   = illegal_q;
      busy_d      = busy_q;

      if (flush)          out_valid_d = 1'b0;
      else if (accept)    out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;

      if (accept) begin
         illegal_d = !dec_legal;
         op_d      = dec_legal ? dec_op : AluAdd;
         rd_d      = dec_legal ? dst : 5'd0;
         rs1_d     = dec_legal ? rf_rdata1 : 32'd0;
         if (!dec_legal)             rs2_d = 32'd0;
         else if (opcode == OpcOp)   rs2_d = rf_rdata2;
         else if (is_shift_imm)      rs2_d = {27'd0, in_instr[24:20]};
         else                        rs2_d = {{20{in_instr[31]}}, in_instr[31:20]};
      end

      // Clears first so that a same-cycle set of the same bit wins.
      if (wb_en) busy_d[wb_rd] = 1'b0;
      if (flush && out_valid_q && !illegal_q && (rd_q != 5'd0)) busy_d[rd_q] = 1'b0;
      if (accept && dec_legal && (dst != 5'd0)) busy_d[dst] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         rs1_q       <= 32'd0;
         rs2_q       <= 32'd0;
         op_q        <= 5'd0;
         rd_q        <= 5'd0;
         illegal_q   <= 1'b0;
         busy_q      <= 32'd0;
      end else begin
         out_valid_q <= out_valid_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         illegal_q   <= illegal_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign rs1       = rs1_q;
   assign rs2       = rs2_q;
   assign op        = op_q;
   assign rd        = rd_q;
   assign illegal   = illegal_q;

endmodule
